// File: rtl/mips_enc_pkg.sv
// Shared constants and helpers for the MIPS instruction encoder.
package mips_enc_pkg;

   localparam logic [1:0] FMT_R    = 2'd0;
   localparam logic [1:0] FMT_I    = 2'd1;
   localparam logic [1:0] FMT_J    = 2'd2;
   localparam logic [1:0] FMT_RSVD = 2'd3;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam int OP_W     = 6;
   localparam int REG_W    = 5;
   localparam int SHAMT_W  = 5;
   localparam int FUNCT_W  = 6;
   localparam int IMM_W    = 16;
   localparam int TARGET_W = 26;
   localparam int INSTR_W  = 32;
   localparam int TAG_W    = 2;
   localparam int CNT_W    = 6;

   // I opcodes 0/2/3 collide with R-type and jumps; J must be j or jal.
   function automatic logic is_legal(input logic [1:0] fmt, input logic [OP_W-1:0] op);
      logic ok;
      ok = 1'b0;
      case (fmt)
         FMT_R:   ok = 1'b1;
         FMT_I:   ok = !((op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL));
         FMT_J:   ok = (op == OP_J) || (op == OP_JAL);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/enc_fifo.sv
// Parameterised DEPTH x WIDTH synchronous FIFO; head is read from registered storage.
module enc_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 32,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [PTR_W:0]   level,
   output logic             full,
   output logic             empty
);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   level_q, level_d;
   logic             do_push, do_pop;

   assign full    = (level_q == LVL_FULL);
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/mips_instr_encoder.sv
// Packs MIPS R/I/J field sets into words and issues them through a FIFO.
// Optional per-class issue counters are enabled with `define ENC_STATS_EN.
module mips_instr_encoder
   import mips_enc_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_fmt,
   input  logic [OP_W-1:0]     in_opcode,
   input  logic [REG_W-1:0]    in_rs,
   input  logic [REG_W-1:0]    in_rt,
   input  logic [REG_W-1:0]    in_rd,
   input  logic [SHAMT_W-1:0]  in_shamt,
   input  logic [FUNCT_W-1:0]  in_funct,
   input  logic [IMM_W-1:0]    in_imm,
   input  logic [TARGET_W-1:0] in_target,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [INSTR_W-1:0]  out_instr,
   output logic [PTR_W:0]      level,
   output logic [CNT_W-1:0]    err_cnt
`ifdef ENC_STATS_EN
  ,output logic [CNT_W-1:0]    cnt_r,
   output logic [CNT_W-1:0]    cnt_i,
   output logic [CNT_W-1:0]    cnt_j
`endif
);

`ifdef ENC_STATS_EN
   localparam int FIFO_W = INSTR_W + TAG_W;
`else
   localparam int FIFO_W = INSTR_W;
`endif

   logic [INSTR_W-1:0] instr_enc;
   logic [FIFO_W-1:0]  fifo_wdata, fifo_rdata;
   logic               fifo_full, fifo_empty;
   logic               accept, legal, push, pop;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   always_comb begin
      instr_enc = '0;
      case (in_fmt)
         FMT_R:   instr_enc = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
         FMT_I:   instr_enc = {in_opcode, in_rs, in_rt, in_imm};
         FMT_J:   instr_enc = {in_opcode, in_target};
         default: instr_enc = '0;
      endcase
   end

   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;
   assign accept    = in_valid && in_ready;
   assign legal     = is_legal(in_fmt, in_opcode);
   assign push      = accept && legal;
   assign pop       = out_valid && out_ready;
   assign out_instr = fifo_rdata[INSTR_W-1:0];

`ifdef ENC_STATS_EN
   assign fifo_wdata = {in_fmt, instr_enc};
`else
   assign fifo_wdata = instr_enc;
`endif

   enc_fifo #(.DEPTH(DEPTH), .WIDTH(FIFO_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Illegal field sets still complete the handshake but are only counted.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && !legal) begin
         err_cnt_d = sat_inc(err_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;

`ifdef ENC_STATS_EN
   logic [TAG_W-1:0] head_tag;
   logic [CNT_W-1:0] cnt_r_q, cnt_r_d, cnt_i_q, cnt_i_d, cnt_j_q, cnt_j_d;

   assign head_tag = fifo_rdata[FIFO_W-1 -: TAG_W];

   // Counted on issue, using the class tag stored with the word.
   always_comb begin
      cnt_r_d = cnt_r_q;
      cnt_i_d = cnt_i_q;
      cnt_j_d = cnt_j_q;
      if (pop) begin
         case (head_tag)
            FMT_R:   cnt_r_d = sat_inc(cnt_r_q);
            FMT_I:   cnt_i_d = sat_inc(cnt_i_q);
            FMT_J:   cnt_j_d = sat_inc(cnt_j_q);
            default: cnt_r_d = cnt_r_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r_q <= '0;
         cnt_i_q <= '0;
         cnt_j_q <= '0;
      end else begin
         cnt_r_q <= cnt_r_d;
         cnt_i_q <= cnt_i_d;
         cnt_j_q <= cnt_j_d;
      end
   end

   assign cnt_r = cnt_r_q;
   assign cnt_i = cnt_i_q;
   assign cnt_j = cnt_j_q;
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomised and directed bench for mips_instr_encoder against a queue-based model.
module tb_mips_instr_encoder;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [1:0]  inFmt = '0;
   logic [5:0]  inOpcode = '0;
   logic [4:0]  inRs = '0, inRt = '0, inRd = '0, inShamt = '0;
   logic [5:0]  inFunct = '0;
   logic [15:0] inImm = '0;
   logic [25:0] inTarget = '0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] outInstr;
   logic [3:0]  level;
   logic [5:0]  errCnt;
`ifdef ENC_STATS_EN
   logic [5:0]  cntR, cntI, cntJ;
   int          modelCnt [3] = '{0, 0, 0};
`endif

   int          testsRun = 0;
   int          testsFailed = 0;
   logic [31:0] expQ [$];
   int          clsQ [$];
   int          modelErr = 0;

   mips_instr_encoder #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_fmt    (inFmt),
      .in_opcode (inOpcode),
      .in_rs     (inRs),
      .in_rt     (inRt),
      .in_rd     (inRd),
      .in_shamt  (inShamt),
      .in_funct  (inFunct),
      .in_imm    (inImm),
      .in_target (inTarget),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_instr (outInstr),
      .level     (level),
      .err_cnt   (errCnt)
`ifdef ENC_STATS_EN
     ,.cnt_r     (cntR),
      .cnt_i     (cntI),
      .cnt_j     (cntJ)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit modelLegal(input int fmt, input int op);
      if (fmt == 3) return 1'b0;
      if (fmt == 1) return !(op == 0 || op == 2 || op == 3);
      if (fmt == 2) return (op == 2 || op == 3);
      return 1'b1;
   endfunction

   function automatic logic [31:0] modelEncode(input int fmt, input longint op, input longint rs,
                                               input longint rt, input longint rd, input longint sh,
                                               input longint fn, input longint imm, input longint tgt);
      longint w;
      if (fmt == 0)      w = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
      else if (fmt == 1) w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
      else               w = op * 67108864 + tgt;
      return 32'(w);
   endfunction

   // One clock: predict from pre-edge state, then compare after the edge.
   task automatic step();
      int  sz;
      bit  acc, popNow, legalNow;
      logic [31:0] word;
      sz       = expQ.size();
      acc      = inValid && (sz < DEPTH);
      popNow   = (sz != 0) && outReady;
      legalNow = modelLegal(int'(inFmt), int'(inOpcode));
      word     = modelEncode(int'(inFmt), longint'(inOpcode), longint'(inRs), longint'(inRt),
                             longint'(inRd), longint'(inShamt), longint'(inFunct),
                             longint'(inImm), longint'(inTarget));
      @(posedge clk);
      #1;
      if (popNow) begin
         void'(expQ.pop_front());
`ifdef ENC_STATS_EN
         if (modelCnt[clsQ[0]] < 63) modelCnt[clsQ[0]]++;
`endif
         void'(clsQ.pop_front());
      end
      if (acc && legalNow) begin
         expQ.push_back(word);
         clsQ.push_back(int'(inFmt));
      end else if (acc && modelErr < 63) begin
         modelErr++;
      end
      checkOutput("level", 32'(level), 32'(expQ.size()));
      checkOutput("out_valid", 32'(outValid), 32'(expQ.size() != 0));
      checkOutput("in_ready", 32'(inReady), 32'(expQ.size() < DEPTH));
      checkOutput("err_cnt", 32'(errCnt), 32'(modelErr));
      if (expQ.size() != 0) checkOutput("out_instr", outInstr, expQ[0]);
`ifdef ENC_STATS_EN
      checkOutput("cnt_r", 32'(cntR), 32'(modelCnt[0]));
      checkOutput("cnt_i", 32'(cntI), 32'(modelCnt[1]));
      checkOutput("cnt_j", 32'(cntJ), 32'(modelCnt[2]));
`endif
   endtask

   task automatic applyStimulus(input logic v, input logic ordy, input logic [1:0] fmt,
                                input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                input logic [15:0] imm, input logic [25:0] tgt);
      inValid  = v;
      outReady = ordy;
      inFmt    = fmt;
      inOpcode = op;
      inRs     = rs;
      inRt     = rt;
      inRd     = rd;
      inShamt  = sh;
      inFunct  = fn;
      inImm    = imm;
      inTarget = tgt;
      step();
   endtask

   task automatic idle(input logic ordy);
      applyStimulus(1'b0, ordy, 2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
   endtask

   task automatic pushRandomI(input logic ordy);
      applyStimulus(1'b1, ordy, 2'd1, 6'h08, 5'($urandom), 5'($urandom), 5'd0, 5'd0, 6'h0,
                    16'($urandom), 26'h0);
   endtask

   initial begin
      logic [5:0] opTab [6];
      opTab = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h23, 6'h0F};

      #12;
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_out_instr", outInstr, 32'h0);
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_err_cnt", 32'(errCnt), 32'd0);
      checkOutput("rst_in_ready", 32'(inReady), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed encodings, each visible one cycle after its accept.
      applyStimulus(1, 1, 2'd1, 6'h08, 5'd0, 5'd4, 5'd0, 5'd0, 6'h00, 16'h3456, 26'h0);
      checkOutput("addi", outInstr, 32'h20043456);
      applyStimulus(1, 1, 2'd0, 6'h00, 5'd5, 5'd4, 5'd6, 5'd0, 6'h20, 16'h0, 26'h0);
      checkOutput("add", outInstr, 32'h00A43020);
      applyStimulus(1, 1, 2'd0, 6'h00, 5'd0, 5'd3, 5'd3, 5'd1, 6'h02, 16'h0, 26'h0);
      checkOutput("srl", outInstr, 32'h00031842);
      applyStimulus(1, 1, 2'd1, 6'h23, 5'd4, 5'd5, 5'd0, 5'd0, 6'h00, 16'h9ABC, 26'h0);
      checkOutput("lw", outInstr, 32'h8C859ABC);
      applyStimulus(1, 1, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0123456);
      checkOutput("j", outInstr, 32'h08123456);
`ifdef ENC_STATS_EN
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 1, 2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'($urandom));
      end
`endif
      idle(1'b1);
`ifdef ENC_STATS_EN
      checkOutput("stats_r", 32'(cntR), 32'd2);
      checkOutput("stats_i", 32'(cntI), 32'd2);
      checkOutput("stats_j", 32'(cntJ), 32'd4);
`endif

      // Backpressure until full, then drain.
      for (int k = 0; k < 9; k++) pushRandomI(1'b0);
      checkOutput("full_level", 32'(level), 32'd8);
      checkOutput("full_in_ready", 32'(inReady), 32'd0);
      for (int k = 0; k < 8; k++) idle(1'b1);
      checkOutput("drained_level", 32'(level), 32'd0);

      // Illegal drops.
      applyStimulus(1, 1, 2'd3, 6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h1, 26'h1);
      applyStimulus(1, 1, 2'd2, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h5);
      applyStimulus(1, 1, 2'd1, 6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h7, 26'h0);
      checkOutput("illegal_valid", 32'(outValid), 32'd0);
      checkOutput("illegal_err3", 32'(errCnt), 32'd3);
      for (int k = 0; k < 70; k++) begin
         applyStimulus(1, 1, 2'd3, 6'($urandom), 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
      end
      checkOutput("illegal_sat", 32'(errCnt), 32'd63);

      // Simultaneous push/pop at level 3 and at full.
      for (int k = 0; k < 3; k++) pushRandomI(1'b0);
      pushRandomI(1'b1);
      checkOutput("simul_level3", 32'(level), 32'd3);
      for (int k = 0; k < 5; k++) pushRandomI(1'b0);
      pushRandomI(1'b1);
      checkOutput("simul_full_pop", 32'(level), 32'd7);
      for (int k = 0; k < 7; k++) idle(1'b1);

      // Asynchronous reset mid-stream.
      for (int k = 0; k < 5; k++) pushRandomI(1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(outValid), 32'd0);
      checkOutput("midrst_level", 32'(level), 32'd0);
      checkOutput("midrst_err", 32'(errCnt), 32'd0);
      checkOutput("midrst_instr", outInstr, 32'h0);
      expQ.delete();
      clsQ.delete();
      modelErr = 0;
`ifdef ENC_STATS_EN
      modelCnt = '{0, 0, 0};
`endif
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1, 0, 2'd0, 6'h00, 5'd5, 5'd4, 5'd6, 5'd0, 6'h20, 16'h0, 26'h0);
      checkOutput("post_rst_add", outInstr, 32'h00A43020);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), opTab[$urandom_range(0, 5)],
                       5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                       16'($urandom), 26'($urandom));
      end
      for (int k = 0; k < 9; k++) idle(1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Producer end of the instruction stream consumed by the instruction-class counter: packs MIPS R/I/J field sets into 32-bit instruction words.
- Buffers encoded words in a small FIFO and issues one word per cycle to the downstream consumer over a valid/ready handshake.
- Used as the stimulus/issue source in front of the counting and decode blocks.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  field set presented
- in_ready  output  1  encoder can accept; equals !full
- in_fmt  input  2  0=R, 1=I, 2=J, 3=reserved
- in_opcode  input  6  opcode; ignored for R
- in_rs  input  5  rs field
- in_rt  input  5  rt field
- in_rd  input  5  rd field
- in_shamt  input  5  shamt field
- in_funct  input  6  funct field
- in_imm  input  16  immediate field
- in_target  input  26  jump target field
- out_valid  output  1  out_instr holds a valid word
- out_ready  input  1  consumer accepts the word
- out_instr  output  32  encoded instruction, FIFO head
- level  output  PTR_W+1  current FIFO occupancy, 0..DEPTH
- err_cnt  output  6  count of dropped illegal inputs; saturates at 63

Behaviour:
- Reset (async assert, sync release): pointers=0, level=0, out_valid=0, out_instr=0, err_cnt=0, in_ready=1.
- Accept: in_valid && in_ready at a rising edge.
- Encoding:
  - R: {6'b000000, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, target}.
- Illegal inputs:
  - fmt=3.
  - I with opcode in {0x00, 0x02, 0x03}.
  - J with opcode not in {0x02, 0x03}.
  - Handling: the handshake still completes, nothing is written, err_cnt increments (saturating).
- Latency: a word accepted at edge N is visible with out_valid=1 after edge N, given an empty FIFO. out_instr comes straight from the registered FIFO head; there is no combinational in->out path.
- Pop: out_valid && out_ready. out_valid equals level!=0.
- Hold: while out_valid && !out_ready, out_instr stays stable.
- Simultaneous push and pop:
  - When not full: both occur and level is unchanged.
  - When full: in_ready=0, so no push happens, and the pop frees one slot for the next cycle.
  - When empty: a push and a pop cannot coincide, since out_valid=0.
- Pointers wrap modulo DEPTH. Full is level==DEPTH; empty is level==0.
- Reset mid-stream discards all contents immediately. No partial word is ever emitted.
- Order is strictly FIFO. Illegal drops do not create holes.

Optional Feature:
- Macro: ENC_STATS_EN.
- Defined:
  - Adds outputs cnt_r, cnt_i, cnt_j, each 6 bits.
  - Each counts popped (issued) words by original class, not accepted ones.
  - Counters saturate at 63 and reset to 0.
  - Class is stored as a 2-bit tag alongside each FIFO entry.
- Undefined: the ports, the tag storage and the counters are absent. Encoder behaviour is otherwise identical.

Decomposition:
- Package mips_enc_pkg holds:
  - FMT_R/FMT_I/FMT_J/FMT_RSVD localparams.
  - OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03.
  - Field-width constants.
- Sub-module enc_fifo: a parameterised DEPTH x width synchronous FIFO with push/pop/level.
- The encoder proper (field packing, legality check, err_cnt, stats) lives in the top module.

Test Plan:
- I, R and J encoding, with out_ready=1 throughout. Inputs, in order, each must appear on out_instr:
  - addi: fmt=I, op=0x08, rs=0, rt=4, imm=0x3456 -> 0x20043456
  - add: fmt=R, rs=5, rt=4, rd=6, shamt=0, funct=0x20 -> 0x00A43020
  - srl: fmt=R, rs=0, rt=3, rd=3, shamt=1, funct=0x02 -> 0x00031842
  - lw: fmt=I, op=0x23, rs=4, rt=5, imm=0x9ABC -> 0x8C859ABC
  - j: fmt=J, op=0x02, target=0x0123456 -> 0x08123456
  - Each word must appear exactly one cycle after its accept.
- Full/backpressure: hold out_ready=0 and push 9 legal words. Required: in_ready drops after the 8th, level=8, and out_instr stays equal to word 0. Then release out_ready: 8 words drain in order and level returns to 0.
- Illegal: push fmt=3, then J with op=0x08, then I with op=0x00. Required: out_valid stays 0 and err_cnt=3. Then 70 illegal pushes -> err_cnt=63.
- Simultaneous: at level=3, push and pop on the same edge -> level stays 3 and order is preserved. At level=8, with in_valid=1 and out_ready=1 -> pop only, level=7.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with level=5. Required: out_valid=0, level=0 and err_cnt=0 immediately. After release, the first new word issues correctly.
- ENC_STATS_EN: issue the five words of the first scenario plus three more J words -> cnt_r=2, cnt_i=2, cnt_j=4.
